// File: rtl/uart_tx_frame.sv
// UART transmitter: one character per ready/valid handshake, internal baud divider,
// configurable data width, optional odd/even parity and one or two stop bits.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // state    | meaning
    // S_IDLE   | line high, ready for a character
    // S_START  | start bit (line low)
    // S_DATA   | data bits, LSB first from the shift register
    // S_PARITY | parity bit of the latched character
    // S_STOP   | STOP_BITS stop periods (line high)

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    logic [BAUD_W-1:0]    r_baud;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_serial;
    logic                 r_done;
    logic                 w_period_end;

    assign w_period_end = (r_baud == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_serial  <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_baud <= w_period_end ? '0 : r_baud + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_serial  <= 1'b1;
                    r_baud    <= '0;
                    r_bit_cnt <= '0;
                    if (tx_valid) begin
                        r_shift  <= tx_data;
                        // Same value as computing it from the latched copy later.
                        r_par    <= (PARITY == 1) ? ~(^tx_data) : (^tx_data);
                        r_serial <= 1'b0;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_period_end) begin
                        r_serial  <= r_shift[0];
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_period_end) begin
                        if (r_bit_cnt == DATA_LAST) begin
                            r_bit_cnt <= '0;
                            if (PARITY != 0) begin
                                r_serial <= r_par;
                                r_state  <= S_PARITY;
                            end else begin
                                r_serial <= 1'b1;
                                r_state  <= S_STOP;
                            end
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_serial  <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_period_end) begin
                        r_serial  <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_period_end) begin
                        if (r_bit_cnt == STOP_LAST) begin
                            r_bit_cnt <= '0;
                            r_done    <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_serial <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_serial = r_serial;
    assign tx_done   = r_done;
    assign tx_busy   = (r_state != S_IDLE);
    assign tx_ready  = (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances cover 8N1, even/odd parity and 5-bit/2-stop frames.
module tb_uart_tx_frame;

    logic            clk;
    logic            rst_n;
    logic [3:0]      v;
    logic [3:0][7:0] d;
    logic [3:0]      ser, rdy, bsy, dn;
    int              sel;
    logic            w_ser, w_rdy, w_bsy, w_dn;
    int              n_assert;
    int              n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(v[0]), .tx_data(d[0]),
        .tx_ready(rdy[0]), .tx_serial(ser[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(v[1]), .tx_data(d[1]),
        .tx_ready(rdy[1]), .tx_serial(ser[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(v[2]), .tx_data(d[2]),
        .tx_ready(rdy[2]), .tx_serial(ser[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));

    uart_tx_frame #(.CLKS_PER_BIT(3), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_5n2 (
        .clk(clk), .rst_n(rst_n), .tx_valid(v[3]), .tx_data(d[3][4:0]),
        .tx_ready(rdy[3]), .tx_serial(ser[3]), .tx_busy(bsy[3]), .tx_done(dn[3]));

    always_comb begin
        w_ser = ser[sel];
        w_rdy = rdy[sel];
        w_bsy = bsy[sel];
        w_dn  = dn[sel];
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves tx_valid high; the edge after this call is the acceptance edge,
    // and on return the bench sits in cycle 1 of the frame.
    task automatic accept(input int which, input logic [7:0] data);
        sel      = which;
        v        = '0;
        v[which] = 1'b1;
        d[which] = data;
        step();
    endtask

    // bits[i] is the expected line level of bit period i; checks cycles 1..F and F+1.
    task automatic frame_check(input string tag, input logic [15:0] bits,
                               input int nper, input int cpb);
        for (int c = 1; c <= nper * cpb; c++) begin
            chk({tag, "_serial"}, {7'd0, w_ser}, {7'd0, bits[(c - 1) / cpb]});
            chk({tag, "_busy"},   {7'd0, w_bsy}, 8'd1);
            chk({tag, "_ready"},  {7'd0, w_rdy}, 8'd0);
            chk({tag, "_done"},   {7'd0, w_dn},  8'd0);
            step();
        end
        chk({tag, "_done_pulse"}, {7'd0, w_dn},  8'd1);
        chk({tag, "_done_ready"}, {7'd0, w_rdy}, 8'd1);
        chk({tag, "_done_busy"},  {7'd0, w_bsy}, 8'd0);
        chk({tag, "_done_line"},  {7'd0, w_ser}, 8'd1);
    endtask

    task automatic idle_check(input string tag, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            step();
            chk({tag, "_idle_done"},  {7'd0, w_dn},  8'd0);
            chk({tag, "_idle_busy"},  {7'd0, w_bsy}, 8'd0);
            chk({tag, "_idle_line"},  {7'd0, w_ser}, 8'd1);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        sel      = 0;
        rst_n    = 1'b0;
        v        = '0;
        d        = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            sel = i;
            #1;
            chk("rst_serial", {7'd0, w_ser}, 8'd1);
            chk("rst_busy",   {7'd0, w_bsy}, 8'd0);
            chk("rst_ready",  {7'd0, w_rdy}, 8'd1);
            chk("rst_done",   {7'd0, w_dn},  8'd0);
        end
        rst_n = 1'b1;
        step();

        // 8N1, 0xA5: periods 0,1,0,1,0,0,1,0,1,1; done at cycle 41
        accept(0, 8'hA5);
        v    = '0;
        d[0] = 8'h00;
        frame_check("a5", {6'd0, 1'b1, 8'hA5, 1'b0}, 10, 4);
        idle_check("a5", 2);

        // even parity, 0x07 has three ones -> parity bit 1
        accept(1, 8'h07);
        v    = '0;
        d[1] = 8'hF0;
        frame_check("even07", {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 4);
        idle_check("even07", 1);

        // odd parity, 0x07 -> parity bit 0
        accept(2, 8'h07);
        v    = '0;
        d[2] = 8'hFF;
        frame_check("odd07", {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 4);
        idle_check("odd07", 1);

        // 5 data bits, 2 stop bits, 3 clocks/bit: 0,1,1,1,1,1,1,1; done at cycle 25
        accept(3, 8'h1F);
        v    = '0;
        d[3] = 8'h00;
        frame_check("d5s2", {8'd0, 1'b1, 1'b1, 5'h1F, 1'b0}, 8, 3);
        idle_check("d5s2", 1);

        // back-to-back: valid held, second acceptance on the done cycle
        accept(0, 8'h55);
        d[0] = 8'hAA;
        frame_check("b2b_55", {6'd0, 1'b1, 8'h55, 1'b0}, 10, 4);
        step();
        v = '0;
        frame_check("b2b_aa", {6'd0, 1'b1, 8'hAA, 1'b0}, 10, 4);
        idle_check("b2b", 2);

        // valid pulsed with 0xFF while busy must not disturb the frame
        accept(0, 8'h81);
        v = '0;
        fork
            frame_check("ign81", {6'd0, 1'b1, 8'h81, 1'b0}, 10, 4);
            begin
                repeat (10) @(posedge clk);
                #3;
                v[0] = 1'b1;
                d[0] = 8'hFF;
                @(posedge clk);
                #3;
                v[0] = 1'b0;
            end
        join
        idle_check("ign81", 6);

        // reset at cycle 17 of a 0xC3 frame (data bit 3 = 0 on the line)
        accept(0, 8'hC3);
        v = '0;
        repeat (16) step();
        chk("pre_rst_line", {7'd0, w_ser}, 8'd0);
        chk("pre_rst_busy", {7'd0, w_bsy}, 8'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_line",  {7'd0, w_ser}, 8'd1);
        chk("mid_rst_busy",  {7'd0, w_bsy}, 8'd0);
        chk("mid_rst_ready", {7'd0, w_rdy}, 8'd1);
        chk("mid_rst_done",  {7'd0, w_dn},  8'd0);
        idle_check("in_rst", 2);
        rst_n = 1'b1;
        idle_check("post_rst", 2);

        accept(0, 8'h3C);
        v = '0;
        frame_check("after_rst_3c", {6'd0, 1'b1, 8'h3C, 1'b0}, 10, 4);
        idle_check("after_rst_3c", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one character per handshake. It has an internal baud-rate divider, configurable data width, optional parity and one or two stop bits. It sits between a byte-stream producer (ready/valid) and the TX pin. It replaces the fixed 8N1, one-bit-per-clock transmitter with a rate-correct, frame-configurable one.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per serial bit period; legal range ≥ 2.
- DATA_BITS, default 8: data bits per frame; legal range 5–9.
- PARITY, default 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, default 1: number of stop bits; 1 or 2.

- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_valid  input  1  producer has a character on tx_data.
- tx_data  input  DATA_BITS  character to send; LSB is transmitted first.
- tx_ready  output  1  transmitter can accept a character (high only in IDLE).
- tx_serial  output  1  serial line, registered; idle level is 1.
- tx_busy  output  1  frame in progress (any state other than IDLE).
- tx_done  output  1  one-cycle pulse after the last stop bit completes.

## Operation
- Reset (asynchronous assert, synchronous release) puts outputs in these states:
  - state = IDLE
  - tx_serial = 1, tx_busy = 0, tx_done = 0, tx_ready = 1
  - baud counter = 0, bit counter = 0
- Handshake: a character is accepted on a rising edge where tx_valid & tx_ready = 1.
  - tx_data is latched into the shift register on that edge.
  - tx_data may change freely after acceptance.
- tx_valid while busy is ignored. No queuing, no error flag.
- FSM states: IDLE → START → DATA → (PARITY if PARITY≠0) → STOP → IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - Each state or bit lasts exactly CLKS_PER_BIT cycles.
  - The state or bit advances when the counter reaches CLKS_PER_BIT-1; the counter then returns to 0.
- START: tx_serial = 0.
- DATA: tx_serial = shift_reg[0]; the register shifts right once per bit period; DATA_BITS periods total.
- PARITY: bit value is XOR of the latched data bits.
  - Odd parity: bit = ~XOR (total count of ones in data + parity is odd).
  - Even parity: bit = XOR.
  - Parity is computed from the latched copy, not from live tx_data.
- STOP: tx_serial = 1 for STOP_BITS × CLKS_PER_BIT cycles.
- On leaving STOP: state = IDLE, tx_done = 1 for exactly one cycle, tx_ready = 1 in that same cycle.
- Frame length F = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits; bit counter is $clog2(DATA_BITS+1) bits. Neither may wrap mid-state.
- Reset asserted mid-frame aborts the frame immediately. tx_serial returns to 1 with no partial stop bit and no tx_done.

## Timing
- Acceptance edge = cycle 0. tx_serial falls to 0 at cycle 1 (registered output, one cycle latency).
- Start bit occupies cycles 1..CLKS_PER_BIT.
- Data bit k occupies cycles 1+(k+1)·CLKS_PER_BIT .. (k+2)·CLKS_PER_BIT.
- Last stop bit ends at cycle F. tx_done = 1 during cycle F+1.
- Back-to-back: if tx_valid is held, the next acceptance occurs at cycle F+1 (the done cycle). Its start bit begins at F+2.
  - This gives a guaranteed minimum idle gap of one clock between frames.
- tx_busy rises at cycle 1 and falls at cycle F+1, aligned with the tx_serial state timing.
- tx_ready = ~tx_busy, combinational from state.

## Test plan
- CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1, send 0xA5.
  - tx_serial per 4-cycle period: 0,1,0,1,0,0,1,0,1,1.
  - tx_done pulses at cycle 41.
  - tx_ready low during cycles 1–40.
- PARITY=2 (even), send 0x07 → parity period = 1. PARITY=1 (odd), send 0x07 → parity period = 0. Each frame is 44 cycles.
- DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=3, send 5'h1F.
  - Expect 0,1,1,1,1,1,1,1 periods (3 cycles each).
  - tx_done at cycle 25.
- tx_valid held high with data 0x55 then 0xAA.
  - Second acceptance at done cycle 41.
  - tx_serial = 1 at cycle 41; second start bit begins at cycle 42.
  - Second frame decodes 0xAA.
- Pulse tx_valid with 0xFF mid-frame while busy → it is ignored; the current frame is unchanged and no extra tx_done occurs.
- Assert rst_n=0 at cycle 17 of a frame → tx_serial = 1 and tx_busy = 0 immediately. No tx_done. After release, a new 0x3C frame transmits correctly.
